// File: rtl/kt_pkg.sv
// Shared types and constants for the KnightsTour remote command link.
package kt_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 5208;
  localparam logic [7:0]  POS_ACK          = 8'hA5;

  typedef enum logic {HIGH, LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_trx.sv
// Full-duplex 8N1 byte UART; receive and transmit halves share nothing but the clock.
module uart_trx
  import kt_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_busy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_fall;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_done_q, tx_done_d;

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_busy = (rx_state_q != RX_IDLE) | rx_fall;
  assign rx_data = rx_shift_q;
  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_rdy     = 1'b0;
    if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CW'(1);
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START;
        rx_cnt_d   = HALF_M1;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = FULL_M1;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_cnt_d   = FULL_M1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_cnt_q == '0) begin
        rx_state_d = RX_IDLE;
        rx_rdy     = rx_sync_q;  // a low stop bit drops the byte silently
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: if (trmt) begin
        tx_state_d = TX_SHIFT;
        tx_shift_d = {1'b1, tx_data, 1'b0};
        tx_cnt_d   = FULL_M1;
        tx_bit_d   = '0;
        tx_done_d  = 1'b0;
      end
      TX_SHIFT: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_cnt_d   = FULL_M1;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Knight-side command link: pairs received UART bytes into 16-bit commands and sends response bytes.
module cmd_uart_wrapper
  import kt_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = BAUD_DIV_DEFAULT,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int unsigned LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TW    = $clog2(LIMIT + 1);

  logic [7:0]  rx_data;
  logic        rx_rdy, rx_busy;

  asm_state_t  state_q, state_d;
  logic [7:0]  high_byte_q, high_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [TW-1:0] tmo_q, tmo_d;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_busy (rx_busy),
    .tx_data (resp),
    .trmt    (trmt),
    .tx_done (tx_done)
  );

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  always_comb begin
    state_d     = state_q;
    high_byte_d = high_byte_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    tmo_d       = tmo_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      HIGH: if (rx_rdy) begin
        high_byte_d = rx_data;
        cmd_rdy_d   = 1'b0;
        tmo_d       = '0;
        state_d     = LOW;
      end
      LOW: begin
        if (rx_rdy) begin
          cmd_d     = {high_byte_q, rx_data};
          cmd_rdy_d = 1'b1;  // overrides a same-cycle clear
          state_d   = HIGH;
        end else if (!rx_busy) begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(LIMIT)) begin
            state_d     = HIGH;
            high_byte_d = '0;
            tmo_d       = '0;
          end
        end
      end
      default: state_d = HIGH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HIGH;
      high_byte_q <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      high_byte_q <= high_byte_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed and randomized checks of cmd_uart_wrapper at a reduced baud divisor.
module tb_cmd_uart_wrapper;
  import kt_pkg::*;

  localparam int unsigned B  = 32;
  localparam int unsigned TB = 20;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int n_cmp = 0;
  int n_err = 0;
  int rises = 0;
  logic rdy_prev = 1'b0;

  cmd_uart_wrapper #(.BAUD_DIV(B), .TIMEOUT_BITS(TB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rises <= rises + 1;
    rdy_prev <= cmd_rdy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame as a remote would put it on the wire.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] frame;
    frame = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) RX = frame[i];
      repeat (B - 1) @(negedge clk);
    end
    @(negedge clk) RX = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] v);
    send_byte(v[15:8], 1'b1);
    send_byte(v[7:0], 1'b1);
  endtask

  task automatic clr_pulse();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle_bits(input int unsigned n);
    repeat (n * B) @(negedge clk);
  endtask

  // Samples TX mid-bit against the ideal frame; optionally fires a stray trmt mid-frame.
  task automatic tx_check(input logic [7:0] r, input bit poke);
    logic [9:0] frame;
    int unsigned w;
    frame = {1'b1, r, 1'b0};
    @(negedge clk) begin resp = r; trmt = 1'b1; end
    @(negedge clk) trmt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = (i == 0) ? B / 2 : B;
      for (int unsigned j = 0; j < w; j++) begin
        @(negedge clk);
        trmt = (poke && i == 3 && j == 0);
        if (trmt) resp = ~r;
      end
      chk($sformatf("tx_bit%0d", i), {31'd0, TX}, {31'd0, frame[i]});
    end
    repeat (B / 2 - 1) @(negedge clk);
    chk("tx_done_early", {31'd0, tx_done}, 32'd0);
    @(negedge clk);
    chk("tx_done_set", {31'd0, tx_done}, 32'd1);
  endtask

  initial begin
    int r0;
    logic [15:0] v;
    logic [7:0]  rb;
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic command
    r0 = rises;
    send_cmd(16'h4BF1);
    chk("c1_cmd", {16'd0, cmd}, 32'h4BF1);
    chk("c1_rdy", {31'd0, cmd_rdy}, 32'd1);
    idle_bits(3);
    chk("c1_rdy_hold", {31'd0, cmd_rdy}, 32'd1);
    chk("c1_rises", rises - r0, 32'd1);
    clr_pulse();
    chk("c1_clr", {31'd0, cmd_rdy}, 32'd0);
    chk("c1_cmd_kept", {16'd0, cmd}, 32'h4BF1);

    // ack transmission, with a stray trmt mid-frame
    tx_check(POS_ACK, 1'b1);
    repeat (5) @(negedge clk);
    chk("tx_done_hold", {31'd0, tx_done}, 32'd1);

    // lone high byte times out
    r0 = rises;
    send_byte(8'h2F, 1'b1);
    idle_bits(25);
    chk("tmo_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_cmd(16'h4001);
    chk("tmo_cmd", {16'd0, cmd}, 32'h4001);
    chk("tmo_rises", rises - r0, 32'd1);
    clr_pulse();

    // framing error on low byte
    r0 = rises;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    chk("frm_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("frm_cmd_kept", {16'd0, cmd}, 32'h4001);
    idle_bits(25);
    send_cmd(16'h6000);
    chk("frm_cmd", {16'd0, cmd}, 32'h6000);
    chk("frm_rises", rises - r0, 32'd1);
    clr_pulse();

    // short low glitch shorter than half a bit
    r0 = rises;
    @(negedge clk) RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    idle_bits(2);
    chk("glitch_no_rdy", rises - r0, 32'd0);
    send_cmd(16'h2000);
    chk("glitch_cmd", {16'd0, cmd}, 32'h2000);
    chk("glitch_rdy", {31'd0, cmd_rdy}, 32'd1);

    // new command without clearing the previous one
    send_byte(8'h5B, 1'b1);
    chk("ovr_drop", {31'd0, cmd_rdy}, 32'd0);
    chk("ovr_cmd_old", {16'd0, cmd}, 32'h2000);
    send_byte(8'hF1, 1'b1);
    chk("ovr_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("ovr_cmd", {16'd0, cmd}, 32'h5BF1);
    clr_pulse();

    // randomized commands and responses
    for (int k = 0; k < 4; k++) begin
      v = 16'($urandom);
      r0 = rises;
      send_byte(v[15:8], 1'b1);
      idle_bits($urandom_range(0, 5));
      send_byte(v[7:0], 1'b1);
      chk($sformatf("rnd_cmd%0d", k), {16'd0, cmd}, {16'd0, v});
      chk($sformatf("rnd_rise%0d", k), rises - r0, 32'd1);
      if ($urandom_range(0, 1) == 1) clr_pulse();
    end
    for (int k = 0; k < 2; k++) begin
      rb = 8'($urandom);
      tx_check(rb, 1'b0);
    end

    // reset in the middle of a transmit frame
    @(negedge clk) begin resp = 8'h00; trmt = 1'b1; end
    @(negedge clk) trmt = 1'b0;
    repeat (3 * B + B / 2) @(negedge clk);
    chk("mid_tx_low", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, TX}, 32'd1);
    chk("mid_rst_done", {31'd0, tx_done}, 32'd0);
    chk("mid_rst_cmd", {16'd0, cmd}, 32'd0);
    chk("mid_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk("post_rst_tx", {31'd0, TX}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
